// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types and widths for the APB master controller
package apb_master_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // A disabled timeout still needs a one-bit counter to keep widths legal.
    function automatic int wait_cnt_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS wait-state counter with timeout detect
module apb_wait_timer
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear,
    input  logic                                   count_en,
    output logic [wait_cnt_w(TIMEOUT_CYCLES)-1:0]  count,
    output logic                                   limit_hit
);

    localparam int CW = wait_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SAT    = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES) : {CW{1'b1}};
    localparam logic [CW-1:0] LIM_M1 = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != SAT)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires in the wait cycle that brings the count up to the limit.
    assign limit_hit = (TIMEOUT_CYCLES > 0) && count_en && (count_q >= LIM_M1);
    assign count     = count_q;

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - single-outstanding APB master with wait-state timeout
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready
);

    localparam int CW = wait_cnt_w(TIMEOUT_CYCLES);

    apb_state_e            state_q, state_d;
    logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic                  wt_clear;
    logic                  wt_en;
    logic                  wt_limit;
    logic [CW-1:0]         wt_count;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (pclk),
        .rst_n    (presetn),
        .clear    (wt_clear),
        .count_en (wt_en),
        .count    (wt_count),
        .limit_hit(wt_limit)
    );

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        wt_clear      = 1'b0;
        wt_en         = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                wt_clear = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else begin
                    wt_en = 1'b1;
                    if (wt_limit) begin
                        rsp_rdata_d   = '0;
                        rsp_timeout_d = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Control strobes decode straight from the state so reset drops them at once.
    assign cmd_ready   = (state_q == IDLE);
    assign psel        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable     = (state_q == ACCESS);
    assign rsp_valid   = (state_q == RESP);
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

    a_wait_cleared: assert property (@(posedge pclk) disable iff (!presetn)
        (state_q == SETUP) |=> (wt_count == '0));

endmodule
